// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings and default widths for the memory arbiter
package mem_arb_pkg;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } state_t;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - icache, dcache and memory port bundle around the arbiter
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
);
  logic          i_mem_read;
  logic [AW-1:0] i_mem_address;
  logic [DW-1:0] i_mem_readdata;
  logic          i_mem_busywait;

  logic          d_mem_read;
  logic          d_mem_write;
  logic [AW-1:0] d_mem_address;
  logic [DW-1:0] d_mem_writedata;
  logic [DW-1:0] d_mem_readdata;
  logic          d_mem_busywait;

  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata;
  logic          mem_busywait;

  modport slave (
    input  i_mem_read, i_mem_address,
    output i_mem_readdata, i_mem_busywait,
    input  d_mem_read, d_mem_write, d_mem_address, d_mem_writedata,
    output d_mem_readdata, d_mem_busywait,
    output mem_read, mem_write, mem_address, mem_writedata,
    input  mem_readdata, mem_busywait
  );

  modport master (
    output i_mem_read, i_mem_address,
    input  i_mem_readdata, i_mem_busywait,
    output d_mem_read, d_mem_write, d_mem_address, d_mem_writedata,
    input  d_mem_readdata, d_mem_busywait,
    input  mem_read, mem_write, mem_address, mem_writedata,
    output mem_readdata, mem_busywait
  );

endinterface

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - two-way picker: round-robin, or dcache-first with MEM_ARB_DCACHE_PRIORITY_EN
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       req_i,
  input  logic       req_d,
  input  logic       last_grant,
  output logic [1:0] pick
);

`ifdef MEM_ARB_DCACHE_PRIORITY_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    pick = 2'b00;
    if (req_d)
      pick[REQ_D] = 1'b1;
    else if (req_i)
      pick[REQ_I] = 1'b1;
  end
`else
  always_comb begin
    pick = 2'b00;
    if (req_i && req_d) begin
      // On a tie the requester that did not own memory last goes next.
      if (last_grant == REQ_I)
        pick[REQ_D] = 1'b1;
      else
        pick[REQ_I] = 1'b1;
    end else if (req_d) begin
      pick[REQ_D] = 1'b1;
    end else if (req_i) begin
      pick[REQ_I] = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one block memory port between icache and dcache
// Build option: MEM_ARB_DCACHE_PRIORITY_EN selects fixed dcache priority instead of round-robin.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  mem_arbiter_if.slave  bus,
  output logic          grant_i,
  output logic          grant_d
);

  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic       req_i, req_d;
  logic [1:0] pick;

  assign req_i = bus.i_mem_read;
  assign req_d = bus.d_mem_read | bus.d_mem_write;

  mem_arb_pick u_pick (
    .req_i      (req_i),
    .req_d      (req_d),
    .last_grant (last_q),
    .pick       (pick)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= REQ_I;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // A grant is held until its owner drops every request, so a dirty
  // write-back and its refill read stay under one ownership.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (pick[REQ_D]) begin
          state_d = GNT_D;
          last_d  = REQ_D;
        end else if (pick[REQ_I]) begin
          state_d = GNT_I;
          last_d  = REQ_I;
        end
      end
      GNT_I:   if (!req_i) state_d = IDLE;
      GNT_D:   if (!req_d) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign grant_i = (state_q == GNT_I);
  assign grant_d = (state_q == GNT_D);

  always_comb begin
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_address   = '0;
    bus.mem_writedata = '0;
    if (grant_i) begin
      bus.mem_read    = bus.i_mem_read;
      bus.mem_address = bus.i_mem_address;
    end else if (grant_d) begin
      bus.mem_read      = bus.d_mem_read;
      bus.mem_write     = bus.d_mem_write;
      bus.mem_address   = bus.d_mem_address;
      bus.mem_writedata = bus.d_mem_writedata;
    end
  end

  // Non-owners that are requesting stall; idle caches are left alone.
  assign bus.i_mem_busywait = grant_i ? bus.mem_busywait : req_i;
  assign bus.d_mem_busywait = grant_d ? bus.mem_busywait : req_d;

  assign bus.i_mem_readdata = bus.mem_readdata;
  assign bus.d_mem_readdata = bus.mem_readdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic grant_i, grant_d;
  int   errors = 0;
  int   checks = 0;

  localparam logic [127:0] WDATA = {4{32'hDEADBEEF}};
  localparam logic [127:0] RDATA = {4{32'hCAFEF00D}};

  mem_arbiter_if #(.AW(28), .DW(128)) bus ();

  mem_arbiter dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus.slave),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    checks++; if (grant_d !== 1'b0) begin errors++; $display("FAIL rst_grant_d: got %0b want 0", grant_d); end
    checks++; if (bus.mem_read !== 1'b0) begin errors++; $display("FAIL rst_mem_read: got %0b want 0", bus.mem_read); end
    repeat (2) tick();
    reset = 1'b1;
    bus.d_mem_read = 1'b1;
    bus.d_mem_address = 28'h0000040;
    tick();
    checks++; if (grant_d !== 1'b1) begin errors++; $display("FAIL rst_pre_grant_d: got %0b want 1", grant_d); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (grant_d !== 1'b0) begin errors++; $display("FAIL rst_async_grant_d: got %0b want 0", grant_d); end
    checks++; if (bus.mem_read !== 1'b0) begin errors++; $display("FAIL rst_async_mem_read: got %0b want 0", bus.mem_read); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rst_async_state: got %0d want 0", dut.state_q); end
    #1;
    reset = 1'b1;
    bus.i_mem_read = 1'b1;
    tick();
    checks++; if (grant_d !== 1'b1 || grant_i !== 1'b0) begin errors++; $display("FAIL rst_first_tie: got d=%0b i=%0b want d=1 i=0", grant_d, grant_i); end
    bus.i_mem_read = 1'b0;
    bus.d_mem_read = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_icache();
    bus.i_mem_read = 1'b1;
    bus.i_mem_address = 28'h0000010;
    bus.mem_busywait = 1'b1;
    #1;
    checks++; if (bus.i_mem_busywait !== 1'b1 || grant_i !== 1'b0) begin errors++; $display("FAIL ic_pre_grant: got bw=%0b gi=%0b want bw=1 gi=0", bus.i_mem_busywait, grant_i); end
    tick();
    checks++; if (grant_i !== 1'b1) begin errors++; $display("FAIL ic_grant: got %0b want 1", grant_i); end
    checks++; if (bus.mem_address !== 28'h0000010) begin errors++; $display("FAIL ic_addr: got %h want 0000010", bus.mem_address); end
    checks++; if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0) begin errors++; $display("FAIL ic_strobes: got r=%0b w=%0b want r=1 w=0", bus.mem_read, bus.mem_write); end
    repeat (4) begin
      tick();
      checks++; if (bus.i_mem_busywait !== 1'b1) begin errors++; $display("FAIL ic_busy: got %0b want 1", bus.i_mem_busywait); end
    end
    bus.mem_busywait = 1'b0;
    bus.mem_readdata = RDATA;
    #1;
    checks++; if (bus.i_mem_busywait !== 1'b0) begin errors++; $display("FAIL ic_busy_fall: got %0b want 0", bus.i_mem_busywait); end
    checks++; if (bus.i_mem_readdata !== RDATA) begin errors++; $display("FAIL ic_rdata: got %h want %h", bus.i_mem_readdata, RDATA); end
    tick();
    bus.i_mem_read = 1'b0;
    tick();
    checks++; if (grant_i !== 1'b0 || bus.mem_read !== 1'b0) begin errors++; $display("FAIL ic_release: got gi=%0b r=%0b want 0 0", grant_i, bus.mem_read); end
  endtask

  task automatic test_dirty_miss();
    bus.d_mem_write = 1'b1;
    bus.d_mem_address = 28'h0ABCDE7;
    bus.d_mem_writedata = WDATA;
    bus.mem_busywait = 1'b1;
    tick();
    checks++; if (grant_d !== 1'b1 || bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0) begin errors++; $display("FAIL dm_write_phase: got gd=%0b w=%0b r=%0b want 1 1 0", grant_d, bus.mem_write, bus.mem_read); end
    checks++; if (bus.mem_address !== 28'h0ABCDE7) begin errors++; $display("FAIL dm_waddr: got %h want 0abcde7", bus.mem_address); end
    checks++; if (bus.mem_writedata !== WDATA) begin errors++; $display("FAIL dm_wdata: got %h want %h", bus.mem_writedata, WDATA); end
    tick();
    bus.d_mem_write = 1'b0;
    bus.d_mem_read = 1'b1;
    bus.d_mem_address = 28'h0123457;
    tick();
    checks++; if (grant_d !== 1'b1) begin errors++; $display("FAIL dm_no_gap: got %0b want 1", grant_d); end
    checks++; if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0 || bus.mem_address !== 28'h0123457) begin errors++; $display("FAIL dm_read_phase: got r=%0b w=%0b a=%h want 1 0 0123457", bus.mem_read, bus.mem_write, bus.mem_address); end
    checks++; if (bus.d_mem_busywait !== 1'b1) begin errors++; $display("FAIL dm_busy: got %0b want 1", bus.d_mem_busywait); end
    bus.mem_busywait = 1'b0;
    tick();
    bus.d_mem_read = 1'b0;
    tick();
    checks++; if (grant_d !== 1'b0) begin errors++; $display("FAIL dm_release: got %0b want 0", grant_d); end
  endtask

  task automatic test_collision();
    pulse_reset();
    bus.i_mem_read = 1'b1;
    bus.i_mem_address = 28'h0000020;
    bus.d_mem_read = 1'b1;
    bus.d_mem_address = 28'h0000030;
    bus.mem_busywait = 1'b1;
    repeat (3) begin
      tick();
      checks++; if (grant_d !== 1'b1 || bus.i_mem_busywait !== 1'b1) begin errors++; $display("FAIL col_hold: got gd=%0b ibw=%0b want 1 1", grant_d, bus.i_mem_busywait); end
    end
    bus.d_mem_read = 1'b0;
    tick();
    checks++; if (grant_d !== 1'b0 || grant_i !== 1'b0 || bus.i_mem_busywait !== 1'b1) begin errors++; $display("FAIL col_idle_gap: got gd=%0b gi=%0b ibw=%0b want 0 0 1", grant_d, grant_i, bus.i_mem_busywait); end
    tick();
    checks++; if (grant_i !== 1'b1 || bus.mem_address !== 28'h0000020) begin errors++; $display("FAIL col_grant_i: got gi=%0b a=%h want 1 0000020", grant_i, bus.mem_address); end
    bus.i_mem_read = 1'b0;
    bus.mem_busywait = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    logic exp_d;
    pulse_reset();
    bus.i_mem_read = 1'b1;
    bus.d_mem_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
`ifdef MEM_ARB_DCACHE_PRIORITY_EN
      exp_d = 1'b1;
`else
      exp_d = (k % 2 == 0);
`endif
      checks++; if (grant_d !== exp_d || grant_i !== !exp_d) begin errors++; $display("FAIL rr_grant_%0d: got d=%0b i=%0b want d=%0b i=%0b", k, grant_d, grant_i, exp_d, !exp_d); end
      if (exp_d) bus.d_mem_read = 1'b0;
      else       bus.i_mem_read = 1'b0;
      tick();
      checks++; if (grant_d !== 1'b0 || grant_i !== 1'b0 || bus.mem_read !== 1'b0) begin errors++; $display("FAIL rr_idle_%0d: got d=%0b i=%0b r=%0b want 0 0 0", k, grant_d, grant_i, bus.mem_read); end
      bus.i_mem_read = 1'b1;
      bus.d_mem_read = 1'b1;
    end
    bus.i_mem_read = 1'b0;
    bus.d_mem_read = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_idle_outputs();
    bus.mem_busywait = 1'b1;
    bus.mem_readdata = WDATA;
    bus.d_mem_writedata = RDATA;
    bus.d_mem_address = 28'h0FFFFFF;
    tick();
    checks++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin errors++; $display("FAIL idle_strobes: got r=%0b w=%0b want 0 0", bus.mem_read, bus.mem_write); end
    checks++; if (bus.mem_address !== 28'h0 || bus.mem_writedata !== 128'h0) begin errors++; $display("FAIL idle_bus: got a=%h wd=%h want zeros", bus.mem_address, bus.mem_writedata); end
    checks++; if (bus.i_mem_busywait !== 1'b0 || bus.d_mem_busywait !== 1'b0) begin errors++; $display("FAIL idle_busywait: got i=%0b d=%0b want 0 0", bus.i_mem_busywait, bus.d_mem_busywait); end
    checks++; if (bus.d_mem_readdata !== WDATA) begin errors++; $display("FAIL idle_rdata_pass: got %h want %h", bus.d_mem_readdata, WDATA); end
  endtask

  initial begin
    bus.i_mem_read = 1'b0;
    bus.i_mem_address = '0;
    bus.d_mem_read = 1'b0;
    bus.d_mem_write = 1'b0;
    bus.d_mem_address = '0;
    bus.d_mem_writedata = '0;
    bus.mem_readdata = '0;
    bus.mem_busywait = 1'b0;
    #1;
    test_reset();
    test_icache();
    test_dirty_miss();
    test_collision();
    test_round_robin();
    test_idle_outputs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
